pcie_dma_rd_packer: RTL

PCIE_DMA_RD_PACKER -- requirements
Module: pcie_dma_rd_packer

---
 rtl/pcie_dma_rd_packer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pcie_dma_rd_packer.sv
// Packs prefetch-FIFO words into 4KB-safe TX bursts; beats pass through combinationally, one CALC cycle per burst.
// Backpressure: tx_ready low holds the head beat stable and suppresses fifo_rd_en; FIFO empty pauses the burst.
module pcie_dma_rd_packer #(
    parameter int BURST_BEATS = 16
) (
    input  logic         rd_clk,
    input  logic         rd_rst,
    input  logic         start,
    input  logic [31:0]  cfg_base_addr,
    input  logic [15:0]  cfg_total_beats,
    output logic         busy,
    output logic         done,
    output logic         fifo_rd_en,
    input  logic         fifo_rd_vld,
    input  logic [127:0] fifo_rd_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [127:0] tx_data,
    output logic         tx_sop,
    output logic         tx_eop,
    output logic [31:0]  tx_addr,
    output logic [8:0]   tx_len
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DATA,
        ST_FIN
    } state_t;

    localparam logic [16:0] BURST_CAP = 17'(BURST_BEATS);

    state_t      state_q, state_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic [8:0]  beat_cnt_q, beat_cnt_d;
    logic [8:0]  tx_len_q, tx_len_d;
    logic [31:0] tx_addr_q, tx_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        in_data;
    logic        beat_fire;
    logic        last_beat;
    logic [12:0] page_bytes;
    logic [16:0] len_cand;
    logic [8:0]  burst_len;

    assign in_data   = (state_q == ST_DATA);
    assign beat_fire = in_data & fifo_rd_vld & tx_ready;
    assign last_beat = (beat_cnt_q == (tx_len_q - 9'd1));

    // Bytes left before the next 4KB page; cur_addr is always 16-byte aligned.
    assign page_bytes = 13'h1000 - {1'b0, cur_addr_q[11:0]};

    always_comb begin
        len_cand = {1'b0, remaining_q};
        if (BURST_CAP < len_cand) begin
            len_cand = BURST_CAP;
        end
        if ({8'd0, page_bytes[12:4]} < len_cand) begin
            len_cand = {8'd0, page_bytes[12:4]};
        end
        burst_len = len_cand[8:0];
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        tx_len_d    = tx_len_q;
        tx_addr_d   = tx_addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_d  = {cfg_base_addr[31:4], 4'h0};
                    remaining_d = cfg_total_beats;
                    state_d     = ST_CALC;
                end
            end
            ST_CALC: begin
                if (remaining_q == 16'd0) begin
                    state_d = ST_FIN;
                end else begin
                    tx_len_d   = burst_len;
                    tx_addr_d  = cur_addr_q;
                    beat_cnt_d = 9'd0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (last_beat) begin
                        cur_addr_d  = cur_addr_q + {19'd0, tx_len_q, 4'h0};
                        remaining_d = remaining_q - {7'd0, tx_len_q};
                        state_d     = ST_CALC;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CALC) || (state_d == ST_DATA);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= 32'd0;
            remaining_q <= 16'd0;
            beat_cnt_q  <= 9'd0;
            tx_len_q    <= 9'd0;
            tx_addr_q   <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            tx_len_q    <= tx_len_d;
            tx_addr_q   <= tx_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign tx_valid   = in_data & fifo_rd_vld;
    assign fifo_rd_en = beat_fire;
    assign tx_data    = fifo_rd_data;
    assign tx_sop     = in_data & (beat_cnt_q == 9'd0);
    assign tx_eop     = in_data & last_beat;
    assign tx_addr    = tx_addr_q;
    assign tx_len     = tx_len_q;

endmodule
